// File: rtl/dmem_stream.sv
// Streaming data-memory tile: internal write/read address generators, per-direction valid, output backpressure.
// Optional DMEM_BYPASS_EN: a same-cycle read/write collision forwards the write datum (write-before-read).
module dmem_stream #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int STRIDE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          cfg_sel_i,
  input  logic [1:0]          cfg_sel_o,
  input  logic [ADDR_W-1:0]   cfg_w_base,
  input  logic [ADDR_W-1:0]   cfg_r_base,
  input  logic [STRIDE_W-1:0] cfg_stride,
  input  logic [ADDR_W:0]     cfg_len,
  input  logic [DATA_W-1:0]   v_s_i,
  input  logic [DATA_W-1:0]   h_s_i,
  input  logic                v_vld_i,
  input  logic                h_vld_i,
  output logic [DATA_W-1:0]   v_s_o,
  output logic [DATA_W-1:0]   h_s_o,
  output logic                v_vld_o,
  output logic                h_vld_o,
  input  logic                o_rdy,
  output logic                busy,
  output logic                done
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [1:0]      SEL_V   = 2'b01;
  localparam logic [1:0]      SEL_H   = 2'b10;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state, state_nx;
  logic                  load;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [1:0]            sel_i, sel_o;
  logic [STRIDE_W-1:0]   stride;
  logic [ADDR_W-1:0]     w_ptr, r_ptr;
  logic [ADDR_W:0]       w_cnt, r_cnt;
  logic [DATA_W-1:0]     o_data;
  logic                  o_vld;
  logic [DATA_W-1:0]     in_data, rd_data;
  logic                  in_vld, w_fire, r_fire, pending;

  // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    in_data = '0;
    in_vld  = 1'b0;
    case (sel_i)
      SEL_V:   begin in_data = v_s_i; in_vld = v_vld_i; end
      SEL_H:   begin in_data = h_s_i; in_vld = h_vld_i; end
      default: ;
    endcase
  end

  assign w_fire  = (w_cnt != '0) && in_vld;
  assign r_fire  = (r_cnt != '0) && (!o_vld || o_rdy);
  // A beat being consumed this cycle does not count as pending, so done follows the last beat directly.
  assign pending = o_vld && !o_rdy;

`ifdef DMEM_BYPASS_EN
  assign rd_data = (w_fire && (w_ptr == r_ptr)) ? in_data : mem[r_ptr];
`else
  assign rd_data = mem[r_ptr];
`endif

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        load     = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN:  if ((w_cnt == '0) && (r_cnt == '0) && !pending) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, avoiding order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      sel_i  <= '0;
      sel_o  <= '0;
      stride <= '0;
      w_ptr  <= '0;
      r_ptr  <= '0;
      w_cnt  <= '0;
      r_cnt  <= '0;
      o_data <= '0;
      o_vld  <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        sel_i  <= cfg_sel_i;
        sel_o  <= cfg_sel_o;
        stride <= cfg_stride;
        w_ptr  <= cfg_w_base;
        r_ptr  <= cfg_r_base;
        w_cnt  <= (cfg_sel_i == SEL_V || cfg_sel_i == SEL_H) ? cfg_len : '0;
        r_cnt  <= (cfg_sel_o == SEL_V || cfg_sel_o == SEL_H) ? cfg_len : '0;
      end else begin
        if (w_fire) begin
          w_ptr <= w_ptr + ADDR_W'(stride);
          w_cnt <= w_cnt - CNT_ONE;
        end
        if (r_fire) begin
          r_ptr <= r_ptr + ADDR_W'(stride);
          r_cnt <= r_cnt - CNT_ONE;
        end
      end
      if (r_fire) begin
        o_data <= rd_data;
        o_vld  <= 1'b1;
      end else if (o_rdy) begin
        o_vld  <= 1'b0;
      end
    end
  end

  // NOTE: the storage array has no reset; contents must survive reset and clearing a RAM is not possible in one cycle anyway.
  always_ff @(posedge clk) begin
    if (w_fire && !rst) mem[w_ptr] <= in_data;
  end

  assign v_vld_o = o_vld && (sel_o == SEL_V);
  assign h_vld_o = o_vld && (sel_o == SEL_H);
  assign v_s_o   = (sel_o == SEL_V) ? o_data : '0;
  assign h_s_o   = (sel_o == SEL_H) ? o_data : '0;
  assign busy    = (state == S_RUN);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_dmem_stream.sv
// Directed bench for dmem_stream: ADDR_W=8 instance for most scenarios, ADDR_W=4 instance for stride wrap.
// Build with +define+DMEM_BYPASS_EN to expect forwarding on a read/write collision.
module tb_dmem_stream;

`ifdef DMEM_BYPASS_EN
  localparam logic [15:0] COLL_EXP = 16'hBBBB;
`else
  localparam logic [15:0] COLL_EXP = 16'hAAAA;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_req = 1'b0;
  logic        use4 = 1'b0;
  logic [1:0]  cfg_sel_i = '0, cfg_sel_o = '0;
  logic [8:0]  cfg_w_base = '0, cfg_r_base = '0;
  logic [3:0]  cfg_stride = '0;
  logic [8:0]  cfg_len = '0;
  logic [15:0] v_s_i = '0, h_s_i = '0;
  logic        v_vld_i = 1'b0, h_vld_i = 1'b0;
  logic        o_rdy = 1'b1;

  logic [15:0] v_s_o8, h_s_o8, v_s_o4, h_s_o4;
  logic        v_vld_o8, h_vld_o8, busy8, done8;
  logic        v_vld_o4, h_vld_o4, busy4, done4;
  logic        start8, start4;

  logic [15:0] s_v, s_h;
  logic        sv_vld, sh_vld, s_busy, s_done;

  logic [15:0] wdat [4];
  logic [15:0] rexp [4];

  int checks = 0;
  int errors = 0;

  assign start8 = start_req && !use4;
  assign start4 = start_req && use4;

  always #5 clk = ~clk;

  dmem_stream #(.DATA_W(16), .ADDR_W(8), .STRIDE_W(4)) dut (
    .clk(clk), .rst(rst), .start(start8),
    .cfg_sel_i(cfg_sel_i), .cfg_sel_o(cfg_sel_o),
    .cfg_w_base(cfg_w_base[7:0]), .cfg_r_base(cfg_r_base[7:0]),
    .cfg_stride(cfg_stride), .cfg_len(cfg_len),
    .v_s_i(v_s_i), .h_s_i(h_s_i), .v_vld_i(v_vld_i), .h_vld_i(h_vld_i),
    .v_s_o(v_s_o8), .h_s_o(h_s_o8), .v_vld_o(v_vld_o8), .h_vld_o(h_vld_o8),
    .o_rdy(o_rdy), .busy(busy8), .done(done8)
  );

  dmem_stream #(.DATA_W(16), .ADDR_W(4), .STRIDE_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .cfg_sel_i(cfg_sel_i), .cfg_sel_o(cfg_sel_o),
    .cfg_w_base(cfg_w_base[3:0]), .cfg_r_base(cfg_r_base[3:0]),
    .cfg_stride(cfg_stride), .cfg_len(cfg_len[4:0]),
    .v_s_i(v_s_i), .h_s_i(h_s_i), .v_vld_i(v_vld_i), .h_vld_i(h_vld_i),
    .v_s_o(v_s_o4), .h_s_o(h_s_o4), .v_vld_o(v_vld_o4), .h_vld_o(h_vld_o4),
    .o_rdy(o_rdy), .busy(busy4), .done(done4)
  );

  always_comb begin
    if (use4) begin
      s_v = v_s_o4; s_h = h_s_o4; sv_vld = v_vld_o4; sh_vld = h_vld_o4;
      s_busy = busy4; s_done = done4;
    end else begin
      s_v = v_s_o8; s_h = h_s_o8; sv_vld = v_vld_o8; sh_vld = h_vld_o8;
      s_busy = busy8; s_done = done8;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [15:0] d, input logic vld);
    v_s_i = '0; v_vld_i = 1'b0; h_s_i = '0; h_vld_i = 1'b0;
    if (sel == 2'b01) begin v_s_i = d; v_vld_i = vld; end
    if (sel == 2'b10) begin h_s_i = d; h_vld_i = vld; end
  endtask

  // Pulses start for one edge and returns in the first busy cycle.
  task automatic do_start(input logic [1:0] si, input logic [1:0] so, input logic [8:0] wb,
                          input logic [8:0] rb, input logic [3:0] st, input logic [8:0] len);
    cfg_sel_i = si; cfg_sel_o = so; cfg_w_base = wb; cfg_r_base = rb;
    cfg_stride = st; cfg_len = len;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    check("busy_rise", s_busy, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!s_done && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, s_done, 1'b1);
    check({tag, "_busy_low"}, s_busy, 1'b0);
    tick();
    check({tag, "_done_pulse"}, s_done, 1'b0);
  endtask

  task automatic write_burst(input logic [1:0] sel, input logic [8:0] base,
                             input logic [3:0] st, input int len);
    do_start(sel, 2'b00, base, 9'd0, st, 9'(len));
    for (int i = 0; i < len; i++) begin
      drive(sel, wdat[i], 1'b1);
      tick();
    end
    drive(sel, 16'h0, 1'b0);
    wait_done("wr", 8);
  endtask

  // With o_rdy held high: beat i at cycle T+2+i, done the cycle after the last beat.
  task automatic read_burst(input string tag, input logic [1:0] so, input logic [8:0] base,
                            input logic [3:0] st, input int len);
    o_rdy = 1'b1;
    do_start(2'b00, so, 9'd0, base, st, 9'(len));
    tick();
    for (int i = 0; i < len; i++) begin
      check({tag, "_data"}, (so == 2'b01) ? s_v : s_h, rexp[i]);
      check({tag, "_vld"}, (so == 2'b01) ? sv_vld : sh_vld, 1'b1);
      check({tag, "_other_vld"}, (so == 2'b01) ? sh_vld : sv_vld, 1'b0);
      tick();
    end
    check({tag, "_done"}, s_done, 1'b1);
    check({tag, "_busy_low"}, s_busy, 1'b0);
    tick();
  endtask

  initial begin
    int hs;
    tick();
    tick();
    rst = 1'b0;
    check("reset_outs8", {v_s_o8, h_s_o8, v_vld_o8, h_vld_o8, busy8, done8}, 36'h0);
    check("reset_outs4", {v_s_o4, h_s_o4, v_vld_o4, h_vld_o4, busy4, done4}, 36'h0);

    // Write then read, stride 1, vertical in / horizontal out.
    wdat = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    write_burst(2'b01, 9'd0, 4'd1, 4);
    rexp = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    read_burst("wr_rd", 2'b10, 9'd0, 4'd1, 4);

    // Stride 3 wrapping in a 16-word tile: addresses 14, 1, 4, 7.
    use4 = 1'b1;
    wdat = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    write_burst(2'b01, 9'd14, 4'd3, 4);
    rexp = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    read_burst("wrap_rd", 2'b01, 9'd14, 4'd3, 4);
    rexp = '{16'h00A2, 16'h00A3, 16'h0, 16'h0};
    read_burst("wrap_addr", 2'b10, 9'd1, 4'd3, 2);
    use4 = 1'b0;

    // Backpressure: o_rdy low for 3 cycles while beat 2 is presented.
    wdat = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
    write_burst(2'b01, 9'h20, 4'd1, 4);
    rexp = wdat;
    do_start(2'b00, 2'b01, 9'd0, 9'h20, 4'd1, 9'd4);
    tick();
    hs = 0;
    for (int k = 0; k < 20; k++) begin
      o_rdy = !(k >= 1 && k <= 3);
      if (s_done) break;
      check("bp_h_vld", sh_vld, 1'b0);
      if (sv_vld) begin
        if (hs < 4) check(o_rdy ? "bp_beat" : "bp_hold", v_s_o8, rexp[hs]);
        else check("bp_extra_beat", hs, 3);
        if (o_rdy) hs++;
      end
      tick();
    end
    o_rdy = 1'b1;
    check("bp_handshakes", hs, 4);
    check("bp_done", s_done, 1'b1);
    tick();

    // Collision at address 5: read and write in the same cycle.
    wdat[0] = 16'hAAAA;
    write_burst(2'b01, 9'd5, 4'd1, 1);
    do_start(2'b01, 2'b10, 9'd5, 9'd5, 4'd0, 9'd1);
    drive(2'b01, 16'hBBBB, 1'b1);
    tick();
    drive(2'b01, 16'h0, 1'b0);
    check("coll_data", h_s_o8, COLL_EXP);
    check("coll_vld", h_vld_o8, 1'b1);
    wait_done("coll", 6);
    rexp[0] = 16'hBBBB;
    read_burst("coll_after", 2'b10, 9'd5, 4'd1, 1);

    // Reset after 2 of 4 write beats, with a read beat held in the output register.
    wdat = '{16'h4141, 16'h4242, 16'h4343, 16'h4444};
    o_rdy = 1'b0;
    do_start(2'b01, 2'b10, 9'h40, 9'd0, 4'd1, 9'd4);
    drive(2'b01, wdat[0], 1'b1);
    tick();
    check("rst_pre_vld", h_vld_o8, 1'b1);
    check("rst_pre_data", h_s_o8, 16'h0011);
    drive(2'b01, wdat[1], 1'b1);
    tick();
    drive(2'b01, wdat[2], 1'b1);
    rst = 1'b1;
    tick();
    check("rst_outs", {v_s_o8, h_s_o8, v_vld_o8, h_vld_o8, busy8, done8}, 36'h0);
    rst = 1'b0;
    drive(2'b01, 16'h0, 1'b0);
    o_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_no_done", done8, 1'b0);
    end
    rexp = '{16'h4141, 16'h4242, 16'h0, 16'h0};
    read_burst("rst_keep", 2'b01, 9'h40, 4'd1, 2);

    // cfg_len = 0: IDLE -> RUN -> DONE with no valid outputs.
    do_start(2'b01, 2'b10, 9'd0, 9'd0, 4'd1, 9'd0);
    check("len0_vld_run", {sv_vld, sh_vld}, 2'b00);
    tick();
    check("len0_done", s_done, 1'b1);
    check("len0_vld_done", {sv_vld, sh_vld}, 2'b00);
    tick();

    // Start while busy must not relatch the configuration.
    wdat = '{16'h5151, 16'h5252, 16'h0, 16'h0};
    do_start(2'b01, 2'b00, 9'h50, 9'd0, 4'd1, 9'd2);
    cfg_sel_i = 2'b10; cfg_w_base = 9'h60; cfg_len = 9'd9;
    start_req = 1'b1;
    drive(2'b01, wdat[0], 1'b1);
    tick();
    start_req = 1'b0;
    drive(2'b01, wdat[1], 1'b1);
    tick();
    drive(2'b01, 16'h0, 1'b0);
    wait_done("busy_start", 8);
    rexp = '{16'h5151, 16'h5252, 16'h0, 16'h0};
    read_burst("busy_start_rd", 2'b01, 9'h50, 4'd1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
